matmul_seq_top: RTL and testbench
=================================

// Module: matmul_seq_top
// PURPOSE
//  Next-generation matrix-multiply accelerator top. Sequential datapath: one output element per cycle.
//  Runtime-selectable square size N (1..MAX_SIZE), done/error status, abort and a cycle counter.
//  Same MMIO/DMA pin interface as the combinational top; sits behind the external MMIO/DMA engine.
//  Matrices are 8-bit unsigned, dense row-major N x N, byte-packed from the buffer base.
// PARAMETERS
//  MMIO_WIDTH     32          MMIO data width
//  MMIO_ADDRBITS  32          MMIO address width
//  DMA_WIDTH      256         DMA data width; MAX_SIZE*MAX_SIZE*8 must be a multiple of it
//  DMA_ADDRBITS   32          DMA address width
//  MAX_SIZE       16          largest supported N; MEMSZ = MAX_SIZE*MAX_SIZE*8/DMA_WIDTH words per buffer
//  OFF_INA/INB/OUT 1/2/3*512*512  DMA byte offsets of A, B and OUT buffers
// PORTS
//  clk          in   1              clock, all state on rising edge
//  rst_n        in   1              reset; asynchronous assert, active-low
//  mmio_w_req   in   1              MMIO write strobe
//  mmio_w_addr  in   MMIO_ADDRBITS  MMIO write register address
//  mmio_w_data  in   MMIO_WIDTH     MMIO write data
//  mmio_r_req   in   1              MMIO read strobe
//  mmio_r_addr  in   MMIO_ADDRBITS  MMIO read register address
//  mmio_r_data  out  MMIO_WIDTH     registered read data; holds until next read
//  dma_w_req    in   1              DMA write strobe
//  dma_w_addr   in   DMA_ADDRBITS   DMA byte address (word-aligned)
//  dma_w_data   in   DMA_WIDTH      DMA write data
//  dma_r_req    in   1              DMA read strobe
//  dma_r_addr   in   DMA_ADDRBITS   DMA byte address (word-aligned)
//  dma_r_data   out  DMA_WIDTH      registered read data; holds until next read
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, mmio_r_data=0, dma_r_data=0, size=MAX_SIZE, done=0, err=0, cycles=0, i=j=0.
//   Memory contents are not reset. Reset mid-RUN aborts immediately; OUT is partially written.
//  MMIO regs (reads: 1-cycle latency; unmapped reads return 0, unmapped writes ignored):
//   0x00 R   MAX_SIZE          0x08 RW  ctrl/status: bit0 running, bit1 done, bit2 err
//   0x10/0x18/0x20 R  OFF_INA/OFF_INB/OFF_OUT  0x28 RW size N   0x30 R cycles (of last/current run)
//  Ctrl write in IDLE: bit0=1 and 1<=size<=MAX_SIZE -> RUN next cycle; clears done, err, cycles; i=j=0.
//   bit0=1 with size 0 or >MAX_SIZE -> err=1, stay IDLE. bit1=1 clears done (W1C); bit2=1 clears err.
//  Ctrl write in RUN: bit0=0 -> abort to IDLE next cycle, done stays 0; bit0=1 ignored. Size writes in RUN ignored.
//  RUN: each cycle out[i][j] = (sum_{k<N} A[i][k]*B[k][j]) mod 256, written to OUT byte i*N+j;
//   cycles += 1; j++ and on j==N-1 wrap j=0,i++. After element (N-1,N-1): IDLE, done=1.
//   Start written in cycle T -> running reads 1 from T+1 through T+N*N; cycles=N*N at completion.
//  Simultaneous completion and abort write in the last cycle: completion wins (done=1).
//  DMA writes: A/B window = [OFF, OFF+MAX_SIZE^2); word index = (addr-OFF)/(DMA_WIDTH/8).
//   Writes outside the windows are ignored; writes to A/B during RUN are dropped.
//  DMA reads: OUT window returns outmem word (current contents, also during RUN); other addresses return 0.
//  OUT bytes beyond N*N are untouched by a run. Same-cycle MMIO and DMA accesses are independent.
// TESTING
//  N=2, A={1,2,3,4}, B={5,6,7,8}, start -> OUT bytes {19,22,43,50}, done=1, cycles=4, running 4 cycles.
//  N=16, A=identity, B byte k=k -> OUT byte k = k (0..255), cycles=256.
//  N=16, all A,B bytes 0xFF -> every OUT byte 0x10 (mod-256 wrap), done=1.
//  size=0 then start -> err=1, running never 1, cycles=0; size=17 -> same; W1C bit2 clears err.
//  N=8 start, write ctrl=0 after 10 cycles -> running=0 next cycle, done=0, cycles=10; DMA write to A in RUN dropped.
//  rst_n low at cycle 5 of N=4 run -> all outputs/regs at reset values asynchronously; restart completes correctly.

Source files
------------

// File: rtl/matmul_seq_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matmul_seq_top - sequential N x N byte matrix multiply, one OUT element/cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
module matmul_seq_top #(
  parameter int MMIO_WIDTH    = 32,
  parameter int MMIO_ADDRBITS = 32,
  parameter int DMA_WIDTH     = 256,
  parameter int DMA_ADDRBITS  = 32,
  parameter int MAX_SIZE      = 16,
  parameter int OFF_INA       = 1 * 512 * 512,
  parameter int OFF_INB       = 2 * 512 * 512,
  parameter int OFF_OUT       = 3 * 512 * 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mmio_w_req,
  input  logic [MMIO_ADDRBITS-1:0] mmio_w_addr,
  input  logic [MMIO_WIDTH-1:0]    mmio_w_data,
  input  logic                     mmio_r_req,
  input  logic [MMIO_ADDRBITS-1:0] mmio_r_addr,
  output logic [MMIO_WIDTH-1:0]    mmio_r_data,
  input  logic                     dma_w_req,
  input  logic [DMA_ADDRBITS-1:0]  dma_w_addr,
  input  logic [DMA_WIDTH-1:0]     dma_w_data,
  input  logic                     dma_r_req,
  input  logic [DMA_ADDRBITS-1:0]  dma_r_addr,
  output logic [DMA_WIDTH-1:0]     dma_r_data
);

  localparam int NB    = MAX_SIZE * MAX_SIZE;
  localparam int BPW   = DMA_WIDTH / 8;
  localparam int MEMSZ = NB * 8 / DMA_WIDTH;
  localparam int IW    = $clog2(NB);
  localparam int LW    = $clog2(BPW);
  localparam int WW    = $clog2(MEMSZ);
  localparam int CW    = $clog2(MAX_SIZE);

  localparam logic [MMIO_ADDRBITS-1:0] REG_MAX  = MMIO_ADDRBITS'(8'h00);
  localparam logic [MMIO_ADDRBITS-1:0] REG_CTRL = MMIO_ADDRBITS'(8'h08);
  localparam logic [MMIO_ADDRBITS-1:0] REG_OFFA = MMIO_ADDRBITS'(8'h10);
  localparam logic [MMIO_ADDRBITS-1:0] REG_OFFB = MMIO_ADDRBITS'(8'h18);
  localparam logic [MMIO_ADDRBITS-1:0] REG_OFFO = MMIO_ADDRBITS'(8'h20);
  localparam logic [MMIO_ADDRBITS-1:0] REG_SIZE = MMIO_ADDRBITS'(8'h28);
  localparam logic [MMIO_ADDRBITS-1:0] REG_CYC  = MMIO_ADDRBITS'(8'h30);

  localparam logic [DMA_ADDRBITS-1:0] A_LO = DMA_ADDRBITS'(OFF_INA);
  localparam logic [DMA_ADDRBITS-1:0] B_LO = DMA_ADDRBITS'(OFF_INB);
  localparam logic [DMA_ADDRBITS-1:0] O_LO = DMA_ADDRBITS'(OFF_OUT);
  localparam logic [DMA_ADDRBITS-1:0] WIN  = DMA_ADDRBITS'(NB);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  state_q;
  logic [MMIO_WIDTH-1:0]   size_q;
  logic                    done_q;
  logic                    err_q;
  logic [MMIO_WIDTH-1:0]   cycles_q;
  logic [CW-1:0]           i_q;
  logic [CW-1:0]           j_q;
  logic [MMIO_WIDTH-1:0]   mmio_rdata_q;
  logic [DMA_WIDTH-1:0]    dma_rdata_q;

  logic [7:0] mem_a_q   [NB];
  logic [7:0] mem_b_q   [NB];
  logic [7:0] mem_out_q [NB];

  logic                  running;
  logic                  ctrl_wr;
  logic                  size_wr;
  logic                  size_ok;
  logic                  abort_req;
  logic                  last_elem;
  logic [CW-1:0]         last_idx;
  logic                  a_hit;
  logic                  b_hit;
  logic                  o_hit;
  logic [WW-1:0]         a_widx;
  logic [WW-1:0]         b_widx;
  logic [WW-1:0]         o_widx;
  logic [IW-1:0]         out_idx;
  logic [7:0]            prod_sum;
  logic [MMIO_WIDTH-1:0] mmio_rd_d;
  logic [DMA_WIDTH-1:0]  dma_rd_d;

  assign running   = (state_q == S_RUN);
  assign ctrl_wr   = mmio_w_req && (mmio_w_addr == REG_CTRL);
  assign size_wr   = mmio_w_req && (mmio_w_addr == REG_SIZE);
  assign size_ok   = (size_q != '0) && (size_q <= MMIO_WIDTH'(MAX_SIZE));
  assign abort_req = ctrl_wr && !mmio_w_data[0];
  assign last_idx  = CW'(size_q - MMIO_WIDTH'(1));
  assign last_elem = (i_q == last_idx) && (j_q == last_idx);

  assign a_hit  = (dma_w_addr >= A_LO) && (dma_w_addr < A_LO + WIN);
  assign b_hit  = (dma_w_addr >= B_LO) && (dma_w_addr < B_LO + WIN);
  assign o_hit  = (dma_r_addr >= O_LO) && (dma_r_addr < O_LO + WIN);
  assign a_widx = WW'((dma_w_addr - A_LO) >> LW);
  assign b_widx = WW'((dma_w_addr - B_LO) >> LW);
  assign o_widx = WW'((dma_r_addr - O_LO) >> LW);

  assign out_idx = IW'(int'(i_q) * int'(size_q) + int'(j_q));

  // Full N-term dot product for the current (i, j); only the low byte is kept.
  always_comb begin
    prod_sum = '0;
    for (int k = 0; k < MAX_SIZE; k++) begin
      if (k < int'(size_q)) begin
        prod_sum = prod_sum + 8'(mem_a_q[IW'(int'(i_q) * int'(size_q) + k)] *
                                 mem_b_q[IW'(k * int'(size_q) + int'(j_q))]);
      end
    end
  end

  always_comb begin
    mmio_rd_d = '0;
    case (mmio_r_addr)
      REG_MAX:  mmio_rd_d = MMIO_WIDTH'(MAX_SIZE);
      REG_CTRL: mmio_rd_d = MMIO_WIDTH'({err_q, done_q, running});
      REG_OFFA: mmio_rd_d = MMIO_WIDTH'(OFF_INA);
      REG_OFFB: mmio_rd_d = MMIO_WIDTH'(OFF_INB);
      REG_OFFO: mmio_rd_d = MMIO_WIDTH'(OFF_OUT);
      REG_SIZE: mmio_rd_d = size_q;
      REG_CYC:  mmio_rd_d = cycles_q;
      default:  mmio_rd_d = '0;
    endcase
  end

  always_comb begin
    dma_rd_d = '0;
    if (o_hit) begin
      for (int l = 0; l < BPW; l++) begin
        dma_rd_d[8*l +: 8] = mem_out_q[{o_widx, LW'(l)}];
      end
    end
  end

  // Buffer storage carries no reset; A/B loads are blocked while a run reads them.
  always_ff @(posedge clk) begin
    if (dma_w_req && !running) begin
      for (int l = 0; l < BPW; l++) begin
        if (a_hit) mem_a_q[{a_widx, LW'(l)}] <= dma_w_data[8*l +: 8];
        if (b_hit) mem_b_q[{b_widx, LW'(l)}] <= dma_w_data[8*l +: 8];
      end
    end
    if (running) mem_out_q[out_idx] <= prod_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      size_q       <= MMIO_WIDTH'(MAX_SIZE);
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cycles_q     <= '0;
      i_q          <= '0;
      j_q          <= '0;
      mmio_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      if (mmio_r_req) mmio_rdata_q <= mmio_rd_d;
      if (dma_r_req)  dma_rdata_q  <= dma_rd_d;
      case (state_q)
        S_IDLE: begin
          if (size_wr) size_q <= mmio_w_data;
          if (ctrl_wr) begin
            if (mmio_w_data[1]) done_q <= 1'b0;
            if (mmio_w_data[2]) err_q  <= 1'b0;
            if (mmio_w_data[0]) begin
              if (size_ok) begin
                state_q  <= S_RUN;
                done_q   <= 1'b0;
                err_q    <= 1'b0;
                cycles_q <= '0;
                i_q      <= '0;
                j_q      <= '0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
        end
        S_RUN: begin
          cycles_q <= cycles_q + MMIO_WIDTH'(1);
          if (j_q == last_idx) begin
            j_q <= '0;
            i_q <= i_q + CW'(1);
          end else begin
            j_q <= j_q + CW'(1);
          end
          // Completion takes priority over an abort arriving in the final cycle.
          if (last_elem) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            i_q     <= '0;
          end else if (abort_req) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mmio_r_data = mmio_rdata_q;
  assign dma_r_data  = dma_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_top.sv
`default_nettype none
// tb_matmul_seq_top: register table, matmul runs, error/abort/reset sequences.
module tb_matmul_seq_top;

  localparam int DW    = 256;
  localparam int NB    = 256;
  localparam int BPW   = DW / 8;
  localparam int WORDS = NB * 8 / DW;
  localparam logic [31:0] OFF_A = 32'd262144;
  localparam logic [31:0] OFF_B = 32'd524288;
  localparam logic [31:0] OFF_O = 32'd786432;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mmio_w_req;
  logic [31:0]   mmio_w_addr;
  logic [31:0]   mmio_w_data;
  logic          mmio_r_req;
  logic [31:0]   mmio_r_addr;
  logic [31:0]   mmio_r_data;
  logic          dma_w_req;
  logic [31:0]   dma_w_addr;
  logic [DW-1:0] dma_w_data;
  logic          dma_r_req;
  logic [31:0]   dma_r_addr;
  logic [DW-1:0] dma_r_data;

  always #5 clk = ~clk;

  matmul_seq_top dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_w_req(mmio_w_req), .mmio_w_addr(mmio_w_addr), .mmio_w_data(mmio_w_data),
    .mmio_r_req(mmio_r_req), .mmio_r_addr(mmio_r_addr), .mmio_r_data(mmio_r_data),
    .dma_w_req(dma_w_req), .dma_w_addr(dma_w_addr), .dma_w_data(dma_w_data),
    .dma_r_req(dma_r_req), .dma_r_addr(dma_r_addr), .dma_r_data(dma_r_data)
  );

  typedef struct { string name; logic [DW-1:0] exp; logic [DW-1:0] mask; } sb_t;
  typedef struct { string name; logic [31:0] addr; logic [31:0] exp; } rv_t;

  sb_t        sbq[$];
  rv_t        rv[9];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] ta[NB];
  logic [7:0] tbm[NB];
  logic [7:0] om[NB];
  bit         known[NB];

  task automatic compare(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp, input logic [DW-1:0] mask);
    checks++;
    if ((got & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got & mask, exp & mask);
    end
  endtask

  task automatic sb_pop(input logic [DW-1:0] got);
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got %0h expected an entry", got);
    end else begin
      e = sbq.pop_front();
      compare(e.name, got, e.exp, e.mask);
    end
  endtask

  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mmio_w_req = 1'b1; mmio_w_addr = a; mmio_w_data = d;
    @(negedge clk);
    mmio_w_req = 1'b0;
  endtask

  task automatic mmio_expect(input string name, input logic [31:0] a, input logic [31:0] e);
    sbq.push_back('{name, DW'(e), DW'(32'hFFFF_FFFF)});
    @(negedge clk);
    mmio_r_req = 1'b1; mmio_r_addr = a;
    @(negedge clk);
    mmio_r_req = 1'b0;
    sb_pop(DW'(mmio_r_data));
  endtask

  task automatic dma_wr(input logic [31:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    dma_w_req = 1'b1; dma_w_addr = a; dma_w_data = d;
    @(negedge clk);
    dma_w_req = 1'b0;
  endtask

  task automatic dma_expect(input string name, input logic [31:0] a,
                            input logic [DW-1:0] e, input logic [DW-1:0] m);
    sbq.push_back('{name, e, m});
    @(negedge clk);
    dma_r_req = 1'b1; dma_r_addr = a;
    @(negedge clk);
    dma_r_req = 1'b0;
    sb_pop(dma_r_data);
  endtask

  function automatic logic [DW-1:0] out_word(input int w);
    logic [DW-1:0] v;
    v = '0;
    for (int l = 0; l < BPW; l++) v[8*l +: 8] = om[w*BPW + l];
    return v;
  endfunction

  function automatic logic [DW-1:0] out_mask(input int w);
    logic [DW-1:0] v;
    v = '0;
    for (int l = 0; l < BPW; l++) if (known[w*BPW + l]) v[8*l +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic load_ab();
    for (int w = 0; w < WORDS; w++) begin
      logic [DW-1:0] da, db;
      for (int l = 0; l < BPW; l++) begin
        da[8*l +: 8] = ta[w*BPW + l];
        db[8*l +: 8] = tbm[w*BPW + l];
      end
      dma_wr(OFF_A + 32'(w*BPW), da);
      dma_wr(OFF_B + 32'(w*BPW), db);
    end
  endtask

  task automatic check_out(input string tag);
    for (int w = 0; w < WORDS; w++)
      dma_expect($sformatf("%s_out_w%0d", tag, w), OFF_O + 32'(w*BPW), out_word(w), out_mask(w));
  endtask

  // Start, then read ctrl every cycle for a fixed window and count running=1 samples.
  task automatic start_and_count(input int window, output int rc);
    mmio_wr(32'h08, 32'h1);
    mmio_r_req = 1'b1; mmio_r_addr = 32'h08;
    rc = 0;
    for (int c = 0; c < window; c++) begin
      @(negedge clk);
      if (mmio_r_data[0]) rc++;
    end
    mmio_r_req = 1'b0;
  endtask

  task automatic run_full(input int n, input string tag);
    int rc;
    mmio_wr(32'h28, 32'(n));
    start_and_count(n*n + 6, rc);
    compare({tag, "_running_cycles"}, DW'(rc), DW'(n*n), '1);
    mmio_expect({tag, "_status"}, 32'h08, 32'h2);
    mmio_expect({tag, "_cycles"}, 32'h30, 32'(n*n));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < n; k++) s += 32'(ta[i*n + k]) * 32'(tbm[k*n + j]);
        om[i*n + j] = s[7:0];
        known[i*n + j] = 1'b1;
      end
    end
    check_out(tag);
  endtask

  task automatic check_reset_regs(input string tag);
    foreach (rv[t]) mmio_expect({tag, "_", rv[t].name}, rv[t].addr, rv[t].exp);
  endtask

  initial begin
    int rc;
    rst_n = 1'b0;
    mmio_w_req = 1'b0; mmio_w_addr = '0; mmio_w_data = '0;
    mmio_r_req = 1'b0; mmio_r_addr = '0;
    dma_w_req = 1'b0; dma_w_addr = '0; dma_w_data = '0;
    dma_r_req = 1'b0; dma_r_addr = '0;

    rv[0] = '{"max_size", 32'h00, 32'd16};
    rv[1] = '{"ctrl",     32'h08, 32'd0};
    rv[2] = '{"off_ina",  32'h10, 32'h0004_0000};
    rv[3] = '{"off_inb",  32'h18, 32'h0008_0000};
    rv[4] = '{"off_out",  32'h20, 32'h000C_0000};
    rv[5] = '{"size",     32'h28, 32'd16};
    rv[6] = '{"cycles",   32'h30, 32'd0};
    rv[7] = '{"unmap04",  32'h04, 32'd0};
    rv[8] = '{"unmap38",  32'h38, 32'd0};

    repeat (3) @(negedge clk);
    compare("reset_mmio_r_data", DW'(mmio_r_data), '0, '1);
    compare("reset_dma_r_data", dma_r_data, '0, '1);
    rst_n = 1'b1;
    check_reset_regs("reset");

    // Illegal sizes
    mmio_wr(32'h28, 32'd0);
    mmio_expect("size0_readback", 32'h28, 32'd0);
    start_and_count(10, rc);
    compare("size0_never_running", DW'(rc), '0, '1);
    mmio_expect("size0_err", 32'h08, 32'h4);
    mmio_expect("size0_cycles", 32'h30, 32'd0);
    mmio_wr(32'h08, 32'h4);
    mmio_expect("size0_err_w1c", 32'h08, 32'h0);
    mmio_wr(32'h28, 32'd17);
    start_and_count(10, rc);
    compare("size17_never_running", DW'(rc), '0, '1);
    mmio_expect("size17_err", 32'h08, 32'h4);
    mmio_wr(32'h08, 32'h4);
    mmio_expect("size17_err_w1c", 32'h08, 32'h0);

    // N=16 identity x ramp
    for (int b = 0; b < NB; b++) begin
      ta[b]  = ((b / 16) == (b % 16)) ? 8'd1 : 8'd0;
      tbm[b] = 8'(b);
    end
    load_ab();
    run_full(16, "ident16");
    compare("ident16_byte200", DW'(om[200]), DW'(8'd200), '1);

    // N=16 all 0xFF -> every byte wraps to 0x10
    for (int b = 0; b < NB; b++) begin ta[b] = 8'hFF; tbm[b] = 8'hFF; end
    load_ab();
    run_full(16, "ff16");
    dma_expect("ff16_const_w7", OFF_O + 32'd224, {BPW{8'h10}}, '1);

    // N=2 small example; bytes beyond 4 keep 0x10
    for (int b = 0; b < NB; b++) begin ta[b] = 8'd0; tbm[b] = 8'd0; end
    ta[0] = 8'd1; ta[1] = 8'd2; ta[2] = 8'd3; ta[3] = 8'd4;
    tbm[0] = 8'd5; tbm[1] = 8'd6; tbm[2] = 8'd7; tbm[3] = 8'd8;
    load_ab();
    run_full(2, "n2");
    dma_expect("n2_const_w0", OFF_O, DW'({32'h1010_1010, 32'h322B_1613}), DW'(64'hFFFF_FFFF_FFFF_FFFF));
    mmio_wr(32'h08, 32'h2);
    mmio_expect("n2_done_w1c", 32'h08, 32'h0);
    dma_expect("dma_unmapped_read", OFF_A, '0, '1);

    // N=8 abort after 10 run cycles, with a dropped A write during the run
    for (int b = 0; b < NB; b++) begin ta[b] = 8'($urandom); tbm[b] = 8'($urandom); end
    load_ab();
    mmio_wr(32'h28, 32'd8);
    mmio_wr(32'h08, 32'h1);
    dma_w_req = 1'b1; dma_w_addr = OFF_A; dma_w_data = {BPW{8'hAA}};
    @(negedge clk);
    dma_w_req = 1'b0;
    repeat (8) @(negedge clk);
    mmio_w_req = 1'b1; mmio_w_addr = 32'h08; mmio_w_data = 32'h0;
    @(negedge clk);
    mmio_w_req = 1'b0;
    mmio_expect("abort_status", 32'h08, 32'h0);
    mmio_expect("abort_cycles", 32'h30, 32'd10);
    run_full(8, "rerun8");

    // Asynchronous reset during an N=4 run, then restart
    for (int b = 0; b < NB; b++) begin ta[b] = 8'($urandom); tbm[b] = 8'($urandom); end
    load_ab();
    mmio_wr(32'h28, 32'd4);
    dma_expect("pre_reset_out_w0", OFF_O, out_word(0), out_mask(0));
    mmio_wr(32'h08, 32'h1);
    mmio_r_req = 1'b1; mmio_r_addr = 32'h00;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compare("async_rst_mmio_r_data", DW'(mmio_r_data), '0, '1);
    compare("async_rst_dma_r_data", dma_r_data, '0, '1);
    mmio_r_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_regs("midrun_reset");
    run_full(4, "restart4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
